// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word fetches, buffers responses in a small FIFO,
// hands {pc, instr} to decode. Optional perf counters under `ifdef FETCH_PERF_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushes
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW+1:0] DEPTH_W = (PW+2)'(DEPTH);

  typedef enum logic {BOOT, RUN} state_t;

  state_t        state, state_nx;
  logic [31:0]   pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic          discard;
  logic [31:0]   q_pc    [DEPTH];
  logic [31:0]   q_instr [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, next_rd;
  logic [PW:0]   count, count_nx;
  logic [PW+1:0] occupancy;
  logic          pop, push, flush, issue;
  logic [31:0]   head_pc_nx, head_instr_nx;

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign push      = inflight & ~discard & ~flush;
  assign imem_req  = issue;
  assign imem_addr = pc;
  assign occupancy = (PW+2)'(count) + (PW+2)'(inflight) - (PW+2)'(pop);
  assign next_rd   = rd_ptr + PW'(pop);
  assign count_nx  = count - (PW+1)'(pop) + (PW+1)'(push);

  always_comb begin
    state_nx = state;
    flush    = 1'b0;
    issue    = 1'b0;
    case (state)
      BOOT: state_nx = RUN;
      RUN: begin
        flush = redirect_valid;
        issue = fetch_en & ~redirect_valid & (occupancy < DEPTH_W);
      end
      default: state_nx = BOOT;
    endcase
  end

  // Registered head: when the queue would otherwise be empty after a pop, the
  // response being pushed this cycle becomes the head directly.
  always_comb begin
    head_pc_nx    = q_pc[next_rd];
    head_instr_nx = q_instr[next_rd];
    if (push && (next_rd == wr_ptr)) begin
      head_pc_nx    = inflight_pc;
      head_instr_nx = imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]    <= inflight_pc;
      q_instr[wr_ptr] <= imem_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      discard     <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      out_pc      <= '0;
      out_instr   <= '0;
    end else begin
      state    <= state_nx;
      inflight <= issue;
      discard  <= flush & inflight;
      if (issue) begin
        inflight_pc <= pc;
        pc          <= pc + 32'd4;
      end
      if (flush) begin
        pc     <= redirect_pc & 32'hFFFF_FFFC;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        rd_ptr <= next_rd;
        count  <= count_nx;
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (count_nx != '0) begin
          out_pc    <= head_pc_nx;
          out_instr <= head_instr_nx;
        end
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_flushes <= '0;
    end else begin
      if (pop)   perf_fetched <= perf_fetched + 32'd1;
      if (flush) perf_flushes <= perf_flushes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a queue-based reference model; a second
// instance with RESET_PC=FFFFFFF8 checks address wrap right after reset.
module tb_fetch_unit;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en, redirect_valid, out_ready;
  logic [31:0] redirect_pc;
  logic        imem_req, out_valid;
  logic [31:0] imem_addr, imem_rdata, out_instr, out_pc;
  logic        wrap_req, wrap_valid;
  logic [31:0] wrap_addr, wrap_rdata, wrap_instr, wrap_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_flushes, wrap_pf, wrap_pfl;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_flushes(perf_flushes)
`endif
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_wrap (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_req(wrap_req), .imem_addr(wrap_addr),
    .imem_rdata(wrap_rdata), .out_valid(wrap_valid), .out_ready(out_ready),
    .out_instr(wrap_instr), .out_pc(wrap_pc)
`ifdef FETCH_PERF_EN
    , .perf_fetched(wrap_pf), .perf_flushes(wrap_pfl)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference model state
  ent_t        mq[$];
  logic [31:0] m_pc;
  bit          m_run;
  bit          m_pend;
  logic [31:0] m_pend_pc;
  logic [31:0] m_last_pc, m_last_instr;
  logic [31:0] m_fetched, m_flushes;
  bit          e_pop, e_req;

  // stimulus knobs
  int          p_fetch, p_ready, p_redir;
  bit          use_tgt;
  logic [31:0] tgt;
  logic        req_s, wreq_s;
  logic [31:0] addr_s, waddr_s;

  bit          w_en;
  int          w_idx;
  logic [31:0] w_exp [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a >> 2;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc = 32'h0;
    m_run = 1'b0;
    m_pend = 1'b0;
    m_pend_pc = 32'h0;
    m_last_pc = 32'h0;
    m_last_instr = 32'h0;
    m_fetched = 32'h0;
    m_flushes = 32'h0;
  endtask

  task automatic step();
    int occ;
    @(negedge clk);
    e_pop = (mq.size() != 0) && out_ready;
    occ   = mq.size() + int'(m_pend) - int'(e_pop);
    e_req = reset && m_run && fetch_en && !redirect_valid && (occ < DEPTH);
    if (mq.size() != 0) begin
      m_last_pc    = mq[0].pc;
      m_last_instr = mq[0].instr;
    end
    check32("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    check32("out_pc", out_pc, m_last_pc);
    check32("out_instr", out_instr, m_last_instr);
    check32("imem_req", 32'(imem_req), 32'(e_req));
    check32("imem_addr", imem_addr, m_pc);
`ifdef FETCH_PERF_EN
    check32("perf_fetched", perf_fetched, m_fetched);
    check32("perf_flushes", perf_flushes, m_flushes);
`endif
    if (w_en && wrap_valid && w_idx < 4) begin
      check32("wrap_pc", wrap_pc, w_exp[w_idx]);
      check32("wrap_instr", wrap_instr, mem_word(w_exp[w_idx]));
      w_idx++;
    end
    req_s = imem_req;  addr_s = imem_addr;
    wreq_s = wrap_req; waddr_s = wrap_addr;

    @(posedge clk);
    if (!reset) begin
      model_reset();
    end else if (!m_run) begin
      m_run = 1'b1;
    end else begin
      if (e_pop) begin
        void'(mq.pop_front());
        m_fetched++;
      end
      if (m_pend && !redirect_valid) mq.push_back('{m_pend_pc, mem_word(m_pend_pc)});
      m_pend = e_req;
      if (e_req) begin
        m_pend_pc = m_pc;
        m_pc      = m_pc + 32'd4;
      end
      if (redirect_valid) begin
        mq.delete();
        m_pc = redirect_pc & 32'hFFFF_FFFC;
        m_flushes++;
      end
    end

    #1;
    imem_rdata     = req_s  ? mem_word(addr_s)  : $urandom;
    wrap_rdata     = wreq_s ? mem_word(waddr_s) : $urandom;
    fetch_en       = ($urandom_range(99) < p_fetch);
    out_ready      = ($urandom_range(99) < p_ready);
    redirect_valid = ($urandom_range(99) < p_redir);
    if (use_tgt)                  redirect_pc = tgt;
    else if ($urandom_range(3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(15));
    else                          redirect_pc = $urandom;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    model_reset();
    reset = 1'b0;
    fetch_en = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_rdata = 32'h0; wrap_rdata = 32'h0;
    p_fetch = 100; p_ready = 100; p_redir = 0; use_tgt = 1'b0; tgt = 32'h0;
    w_en = 1'b0; w_idx = 0;

    run(3);
    reset = 1'b1;
    w_en = 1'b1;
    run(12);
    w_en = 1'b0;
    check32("wrap_count", 32'(w_idx), 32'd4);

    // decode stalls, then drains
    p_ready = 0;   run(8);
    p_ready = 100; run(6);

    // redirect to an unaligned target with the queue full / response in flight
    p_ready = 0;   run(3);
    p_ready = 60;  run(2);
    use_tgt = 1'b1; tgt = 32'h0000_0041;
    p_redir = 100; run(1);
    p_redir = 0;   p_ready = 0; run(1);
    p_ready = 100; run(8);

    // redirect coincident with a pop in steady state
    tgt = 32'h0000_0100;
    p_redir = 100; run(1);
    p_redir = 0;   run(8);
    use_tgt = 1'b0;

    p_fetch = 85; p_ready = 70; p_redir = 8;
    run(1500);

    // asynchronous reset while busy
    p_fetch = 100; p_ready = 100; p_redir = 0;
    run(6);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check32("rst_out_valid", 32'(out_valid), 32'd0);
    check32("rst_imem_req", 32'(imem_req), 32'd0);
    check32("rst_out_pc", out_pc, 32'd0);
    check32("rst_imem_addr", imem_addr, 32'd0);
    model_reset();
    run(2);
    reset = 1'b1;
    run(10);

    p_fetch = 80; p_ready = 60; p_redir = 10;
    run(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front end; the producer of the PC stream for the single-cycle MIPS core.
- Issues word addresses to the synchronous InstructionMemory and buffers returned instructions in a small queue.
- Hands {pc, instruction} to decode with a valid/ready handshake.
- Consumes the jump/branch redirect (j, jal, jr, beq, bne, bgez targets): flushes queued and in-flight fetches and restarts at the target.

Parameters:
- RESET_PC, 32'h00000000, first fetch address after reset.
- DEPTH, 2, instruction queue entries (power of two, >=2).

Ports:
- clk  input  1  core clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- fetch_en  input  1  when 0, no new memory requests are issued; the in-flight request still completes.
- redirect_valid  input  1  jump/branch taken this cycle.
- redirect_pc  input  32  target address; bits [1:0] are forced to 0.
- imem_req  output  1  read request to instruction memory this cycle.
- imem_addr  output  32  word-aligned fetch address.
- imem_rdata  input  32  instruction data, valid exactly 1 cycle after imem_req.
- out_valid  output  1  queue head available.
- out_ready  input  1  decode accepts the head.
- out_instr  output  32  head instruction.
- out_pc  output  32  address of the head instruction.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=BOOT, fetch pc=RESET_PC, queue empty, inflight=0, discard=0.
  - Outputs: imem_req=0, imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0.
- FSM:
  - BOOT: one cycle with no request, then RUN unconditionally.
  - RUN: normal operation.
  - A redirect in BOOT is ignored.
- Issue rule, RUN only: imem_req = fetch_en & !redirect_valid & (count + inflight - pop < DEPTH), where pop = out_valid & out_ready.
  - imem_addr = pc.
  - On issue: pc <= pc+4, mod 2^32 (32'hFFFFFFFC wraps to 0), and inflight <= 1.
- Response: the cycle after an issue, {issued pc, imem_rdata} is written to the queue tail at the closing edge, unless discard=1.
  - out_valid rises the following cycle.
  - Fetch-to-decode latency: req at cycle t, out_valid at t+2.
  - Steady-state throughput is 1 instruction/cycle when out_ready=1.
- Queue:
  - FIFO with a registered head; out_instr/out_pc come from the head entry.
  - Pop and push in the same cycle are both honoured.
  - Full: no issue unless a pop occurs in that cycle.
  - Empty: out_valid=0; out_instr/out_pc hold their last value.
- Redirect (redirect_valid=1 in RUN, cycle N):
  - A pop in cycle N is still accepted.
  - At the edge: queue cleared, pc <= {redirect_pc[31:2],2'b00}, and discard <= inflight (the returning response is dropped).
  - No request is issued in cycle N. The request to the target goes out in N+1; out_valid=1 at N+3 with out_pc=target.
  - Back-to-back redirects: the last one wins; each one clears the queue again.
- fetch_en=0: the queue drains normally and pc holds. A redirect is still accepted and updates pc.
- Reset asserted mid-operation: immediate return to the reset values above. The pending response is never written.

Optional Feature:
- FETCH_PERF_EN defined: adds outputs perf_fetched (32) and perf_flushes (32), both reset to 0.
  - perf_fetched increments on each handshake (out_valid&out_ready).
  - perf_flushes increments on each accepted redirect.
  - Both wrap at 2^32.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset release, fetch_en=1, out_ready=1, memory word[i]=i -> imem_req first at cycle 1 with addr 0; out_valid at cycle 3 with out_pc=0, out_instr=0; thereafter one instruction/cycle with pc 4, 8, 12, ...
- out_ready=0 for 6 cycles -> exactly DEPTH=2 entries buffered (pc 0, 4); imem_req stays low; on out_ready=1, pc 0 and 4 are output, then 8, with no gaps or duplicates.
- Redirect to 32'h00000041 while a request is in flight and the queue holds 2 entries -> queued and in-flight data are never output; next out_pc=32'h00000040, 2 cycles after the target request.
- Redirect coincident with a pop of pc 8 -> pc 8 is counted as accepted; the next output is the target; perf_fetched includes pc 8 (FETCH_PERF_EN).
- RESET_PC=32'hFFFFFFF8 -> outputs pc FFFFFFF8, FFFFFFFC, 00000000, 00000004.
- Reset asserted while out_valid=1 and a request is in flight -> out_valid=0 and imem_req=0 immediately; after release, the sequence restarts at RESET_PC with the BOOT cycle.
